// File: rtl/barcode_pkg.sv
// Shared constants, FSM state type and EAN-13 check-digit helper for the
// barcode-to-UART scheduler.
package barcode_pkg;

    localparam int         DIGITS      = 13;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         FRAME_BYTES = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CHECK,
        ST_SEND
    } state_t;

    // Weights 1,3,1,3... from the leftmost digit down to digit 1; the sum of
    // twelve weighted digits never exceeds 216, so 8 bits suffice.
    function automatic logic [3:0] ean13_check(input logic [DIGITS*4-1:0] code);
        logic [7:0] sum;
        logic [7:0] rem;
        sum = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (((DIGITS - 1 - i) % 2) == 1)
                sum = sum + 8'(code[i*4 +: 4]) * 8'd3;
            else
                sum = sum + 8'(code[i*4 +: 4]);
        end
        rem = sum % 8'd10;
        return (rem == 8'd0) ? 4'd0 : 4'(8'd10 - rem);
    endfunction

endpackage

// File: rtl/barcode_tx_sched_sync_pulse.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a one-cycle
// pulse in the destination clock domain.
module sync_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr <= '0;
        else
            sr <= {sr[1:0], din};
    end

    assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/barcode_tx_sched.sv
// Barcode scan scheduler: synchronises scan strobes, validates and de-duplicates
// codes, then streams each as ASCII digits + CR LF. Define CHECKSUM_EN to also
// reject codes whose EAN-13 check digit does not match.
module barcode_tx_sched #(
    parameter int DIGITS         = 13,
    parameter int HOLDOFF_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic [DIGITS*4-1:0]   scan_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
);
    import barcode_pkg::*;

    localparam int N_BYTES = DIGITS + 2;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam int HOLD_W  = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [IDX_W-1:0]  IDX_CR    = IDX_W'(DIGITS);
    localparam logic [IDX_W-1:0]  IDX_LF    = IDX_W'(DIGITS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  scan_pulse;
    logic [DIGITS*4-1:0]   code_q, last_code;
    logic                  dup_valid;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  digit_bad, cks_bad, is_dup, hs, last_hs;
    logic [7:0]            byte_sel;

    sync_pulse u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scan_en),
        .pulse (scan_pulse)
    );

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (code_q[i*4 +: 4] > 4'd9) digit_bad = 1'b1;
    end

`ifdef CHECKSUM_EN
    assign cks_bad = (ean13_check(code_q) != code_q[3:0]);
`else
    assign cks_bad = 1'b0;
`endif

    assign is_dup  = dup_valid && (code_q == last_code) && (hold_cnt != '0);
    assign hs      = tx_valid && tx_ready;
    assign last_hs = (state_q == ST_SEND) && hs && (idx == IDX_LF);
    assign busy    = (state_q != ST_IDLE);

    // idx rests at 0 outside SEND, so the first digit is ready during CHECK.
    always_comb begin
        byte_sel = ASCII_LF;
        if (idx == IDX_CR) byte_sel = ASCII_CR;
        for (int i = 0; i < DIGITS; i++)
            if (idx == IDX_W'(i))
                byte_sel = ASCII_ZERO + {4'h0, code_q[(DIGITS-1-i)*4 +: 4]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (scan_pulse) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_CHECK;
            ST_CHECK:   state_d = (digit_bad || cks_bad || is_dup) ? ST_IDLE : ST_SEND;
            ST_SEND:    if (last_hs) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            last_code <= '0;
            dup_valid <= 1'b0;
            hold_cnt  <= '0;
            idx       <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            case (state_q)
                ST_CAPTURE: code_q <= scan_data;
                ST_CHECK: begin
                    if (digit_bad || cks_bad) begin
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else if (!is_dup) begin
                        tx_valid <= 1'b1;
                        tx_data  <= byte_sel;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        if (idx == IDX_LF) begin
                            idx       <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            last_code <= code_q;
                            dup_valid <= 1'b1;
                            hold_cnt  <= HOLD_LOAD;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= byte_sel;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/barcode_tx_sched.md
# barcode_tx_sched

Scheduler between the barcode scanner and the UART byte transmitter. Takes 13-digit scan results produced in the LCD pixel clock domain, synchronises the strobe, validates the digits (optionally checking the EAN-13 check digit) and suppresses repeats of the same code. It then sequences each accepted code as a 15-byte ASCII frame (13 digits, CR, LF) into the UART transmitter over a valid/ready handshake. It sits in the top level between the scan block and the UART transmitter, in the 50 MHz system clock domain.

## Interface
Parameters:
- DIGITS, 13: digits per code.
- HOLDOFF_CYCLES, 50_000_000: repeat-suppression window in clk cycles (1 s at 50 MHz). Must be ≥ 1.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  scan-result strobe from another clock domain; rising edge means a new result is available
- scan_data  in  DIGITS×4  packed digits; scan_data[12] is the leftmost digit and is sent first; must be stable ≥ 4 clk after scan_en rises
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART accepts a byte at an edge where tx_valid && tx_ready
- busy  out  1  a frame is being captured, checked or sent
- frame_cnt  out  16  count of frames fully sent; wraps
- err_cnt  out  8  count of rejected codes (bad digit or bad checksum); saturates at 255

## Operation
- Input synchroniser: scan_en passes through 2 flops, then rising-edge detect; this gives a 1-cycle scan_pulse.
- States: IDLE → CAPTURE → CHECK → SEND → IDLE.
- IDLE: on scan_pulse, go to CAPTURE.
- CAPTURE: register scan_data into code_q, then go to CHECK.
- CHECK (one cycle):
  - Any digit > 9 → err_cnt++, go to IDLE.
  - With CHECKSUM_EN, a check-digit mismatch → err_cnt++, go to IDLE.
  - If dup_valid && code_q == last_code && hold_cnt != 0 → drop silently, go to IDLE.
  - Otherwise go to SEND with byte index 0.
- SEND: byte index k runs 0..14.
  - k = 0..12 sends 8'h30 + digit(12−k).
  - k = 13 sends 8'h0D; k = 14 sends 8'h0A.
  - The index advances on each handshake.
  - After the handshake on k = 14: frame_cnt++, last_code ← code_q, dup_valid ← 1, hold_cnt ← HOLDOFF_CYCLES−1, go to IDLE.
- hold_cnt decrements by 1 in every cycle where it is nonzero, in any state.
- scan_pulse in any state other than IDLE is ignored. There is no queueing and no counter for these.
- busy = (state != IDLE).
- Reset clears all state. Outputs after reset: tx_valid 0, tx_data 8'h00, busy 0, frame_cnt 0, err_cnt 0. dup_valid is 0 and hold_cnt is 0.
- Reset asserted mid-frame aborts the frame. No partial frame resumes after reset.

## Timing
- scan_en is first sampled high at edge N. scan_pulse is high in cycle N+1 to N+2. CAPTURE runs N+2 to N+3, CHECK runs N+3 to N+4, and tx_valid rises after edge N+4.
- tx_valid holds high with tx_data stable until the accepting edge. The next byte is presented in the following cycle, so the fastest rate is 1 byte per 2 cycles. tx_valid never drops without a handshake.
- tx_ready may be high before tx_valid rises; the block must not depend on tx_ready going low.
- Repeat window: a duplicate code is dropped if its CHECK falls within HOLDOFF_CYCLES−1 cycles after the last LF handshake. A different code is never suppressed.

## Configuration
- CHECKSUM_EN defined: compute the EAN-13 checksum.
  - Weights are 1,3,1,3,… starting at scan_data[12] and ending at scan_data[1].
  - check = (10 − sum mod 10) mod 10, compared with scan_data[0].
  - The sum is at most 216 and fits in 8 bits.
- CHECKSUM_EN undefined: only the digit-range check applies, and any 13 valid digits are sent.

## Structure
- Package barcode_pkg holds:
  - DIGITS, ASCII_ZERO = 8'h30, ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, FRAME_BYTES = 15.
  - The state enum.
  - Function ean13_check(code) returning the computed check digit.
- Sub-module sync_pulse: 2-flop synchroniser plus rising-edge detector with asynchronous active-low reset. Used once here; reusable elsewhere.

## Test plan
- Scan 4006381333931 with tx_ready tied to 1 → bytes "4006381333931",0D,0A in order; tx_valid first high 4 cycles after scan_en; frame_cnt = 1.
- Scan 4006381333932 with CHECKSUM_EN → no tx_valid, err_cnt = 1. Same scan without the macro → a 15-byte frame is sent.
- A scan_data containing digit 4'hA → dropped, err_cnt++, no tx_valid, in both builds.
- With HOLDOFF_CYCLES = 100: same code again 50 cycles after LF → dropped; again 150 cycles after LF → sent; a different code at 10 cycles → sent.
- tx_ready toggled randomly and a second scan_en pulse mid-frame → every byte is stable while valid and exactly 15 bytes are sent; the second scan is ignored and frame_cnt = 1.
- rst_n pulled low at byte 7 → tx_valid goes 0 asynchronously. After release, a new scan yields a complete frame starting from the first digit.
